// File: rtl/gcm_ctrl_pkg.sv
// Shared definitions for the GCM job controller: operand widths and the
// controller state encoding.
package gcm_ctrl_pkg;

  localparam int IV_W  = 96;
  localparam int BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } ctrl_state_t;

endpackage : gcm_ctrl_pkg

// File: rtl/gcm_job_ctrl_rise_det.sv
// Rising-edge detector: remembers the previous input level and flags a
// 0->1 transition for one cycle.
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_q;

  // Previous-cycle level of the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;

endmodule : rise_det

// File: rtl/gcm_job_ctrl.sv
// GCM job controller: accepts one job at a time, launches it on the GCM
// core, waits for the tag with a timeout guard and presents the result
// until the consumer takes it.
module gcm_job_ctrl
  import gcm_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               i_reset_n,
  // Job request
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_new,
  input  logic [0:IV_W-1]    i_req_iv,
  input  logic [0:BLK_W-1]   i_req_key,
  input  logic [0:BLK_W-1]   i_req_pt,
  // GCM core control and operands
  output logic               o_core_new_instance,
  output logic               o_core_pt_instance,
  output logic [0:IV_W-1]    o_core_iv,
  output logic [0:BLK_W-1]   o_core_key,
  output logic [0:BLK_W-1]   o_core_pt,
  // GCM core results
  input  logic [0:BLK_W-1]   i_core_cipher_text,
  input  logic [0:BLK_W-1]   i_core_tag,
  input  logic               i_core_tag_ready,
  // Result handshake
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [0:BLK_W-1]   o_rsp_cipher_text,
  output logic [0:BLK_W-1]   o_rsp_tag,
  output logic               o_rsp_err,
  // Statistics
  output logic [CNT_W-1:0]   o_job_count
);

  // Last counter value that is still allowed to wait; reaching it ends the job.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_t       state;
  logic              new_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              tag_rise;

  // Edge detector runs every cycle so a level already high on WAIT entry
  // is seen as "previously high" and never counts as completion.
  rise_det u_rise_det (
    .clk   (clk),
    .rst_n (i_reset_n),
    .din   (i_core_tag_ready),
    .rise  (tag_rise)
  );

  // Core pulses and ready are decoded straight from the state register.
  assign o_req_ready         = (state == IDLE);
  assign o_core_pt_instance  = (state == LAUNCH);
  assign o_core_new_instance = (state == LAUNCH) && new_q;

  // Job sequencing: accept, launch, wait with timeout, respond.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      // NOTE: operand and result registers are reset too, so nothing from an
      // abandoned job can leak onto the core or response buses afterwards.
      state             <= IDLE;
      new_q             <= 1'b0;
      wait_cnt          <= '0;
      o_core_iv         <= '0;
      o_core_key        <= '0;
      o_core_pt         <= '0;
      o_rsp_valid       <= 1'b0;
      o_rsp_cipher_text <= '0;
      o_rsp_tag         <= '0;
      o_rsp_err         <= 1'b0;
      o_job_count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            // Operands are captured once; the requester may change them afterwards.
            o_core_iv  <= i_req_iv;
            o_core_key <= i_req_key;
            o_core_pt  <= i_req_pt;
            new_q      <= i_req_new;
            state      <= LAUNCH;
          end
        end

        LAUNCH: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          // Completion is checked first so it wins over a coincident timeout.
          if (tag_rise) begin
            o_rsp_cipher_text <= i_core_cipher_text;
            o_rsp_tag         <= i_core_tag;
            o_rsp_err         <= 1'b0;
            o_rsp_valid       <= 1'b1;
            state             <= RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            o_rsp_cipher_text <= '0;
            o_rsp_tag         <= '0;
            o_rsp_err         <= 1'b1;
            o_rsp_valid       <= 1'b1;
            state             <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_job_count <= o_job_count + 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : gcm_job_ctrl
